mips_multi: RTL and testbench

MIPS_MULTI -- requirements
Module: mips_multi

---
 rtl/mips_multi.sv | 252 +++++++++++++++++++++++++
 tb/tb_mips_multi.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_multi.sv
`default_nettype none
// ============================================================================
// Module   : mips_multi
// Purpose  : Multi-cycle MIPS subset core with a single unified
//            instruction/data memory port and a variable-latency handshake.
//            Supports lw, sw, add, sub, and, or, slt, nor, sll, srl, beq,
//            bne, addi, andi, ori, slti, j and jal. Any other opcode or
//            funct parks the core in a terminal HALT state.
// Ports    : clk       - single clock, rising edge
//            reset     - asynchronous active-high reset
//            memaddr   - memory address (pc in FETCH, ALUOut in MEMRD/MEMWR)
//            memread   - read request, held until memready
//            memwrite  - write request, held until memready
//            writedata - store data (register B)
//            readdata  - memory read data, sampled when memready=1
//            memready  - memory completes the current request this cycle
//            pc        - architectural program counter (debug)
//            halted    - high once an unsupported instruction is decoded
// Revision : 1.0 - initial release
// ============================================================================
module mips_multi #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0,
    parameter int               NREGS    = 32
) (
    input  logic             clk,
    input  logic             reset,
    output logic [WIDTH-1:0] memaddr,
    output logic             memread,
    output logic             memwrite,
    output logic [WIDTH-1:0] writedata,
    input  logic [WIDTH-1:0] readdata,
    input  logic             memready,
    output logic [WIDTH-1:0] pc,
    output logic             halted
);

    localparam int c_RA = (NREGS > 1) ? $clog2(NREGS) : 1;

    localparam logic [3:0] c_FETCH  = 4'd0;
    localparam logic [3:0] c_DECODE = 4'd1;
    localparam logic [3:0] c_MEMADR = 4'd2;
    localparam logic [3:0] c_MEMRD  = 4'd3;
    localparam logic [3:0] c_MEMWB  = 4'd4;
    localparam logic [3:0] c_MEMWR  = 4'd5;
    localparam logic [3:0] c_RTEXEC = 4'd6;
    localparam logic [3:0] c_ALUWB  = 4'd7;
    localparam logic [3:0] c_BRANCH = 4'd8;
    localparam logic [3:0] c_IEXEC  = 4'd9;
    localparam logic [3:0] c_IWB    = 4'd10;
    localparam logic [3:0] c_JUMP   = 4'd11;
    localparam logic [3:0] c_HALT   = 4'd12;

    localparam logic [5:0] c_OP_RTYPE = 6'h00;
    localparam logic [5:0] c_OP_J     = 6'h02;
    localparam logic [5:0] c_OP_JAL   = 6'h03;
    localparam logic [5:0] c_OP_BEQ   = 6'h04;
    localparam logic [5:0] c_OP_BNE   = 6'h05;
    localparam logic [5:0] c_OP_ADDI  = 6'h08;
    localparam logic [5:0] c_OP_SLTI  = 6'h0a;
    localparam logic [5:0] c_OP_ANDI  = 6'h0c;
    localparam logic [5:0] c_OP_ORI   = 6'h0d;
    localparam logic [5:0] c_OP_LW    = 6'h23;
    localparam logic [5:0] c_OP_SW    = 6'h2b;

    localparam logic [5:0] c_FN_SLL = 6'h00;
    localparam logic [5:0] c_FN_SRL = 6'h02;
    localparam logic [5:0] c_FN_ADD = 6'h20;
    localparam logic [5:0] c_FN_SUB = 6'h22;
    localparam logic [5:0] c_FN_AND = 6'h24;
    localparam logic [5:0] c_FN_OR  = 6'h25;
    localparam logic [5:0] c_FN_NOR = 6'h27;
    localparam logic [5:0] c_FN_SLT = 6'h2a;

    logic [3:0]       r_state, w_next;
    logic [WIDTH-1:0] r_pc, r_a, r_b, r_aluout, r_mdr;
    logic [31:0]      r_ir;
    logic [WIDTH-1:0] r_rf [NREGS];

    logic [5:0]       w_op, w_funct;
    logic [4:0]       w_shamt;
    logic [c_RA-1:0]  w_rs, w_rt, w_rd;
    logic [WIDTH-1:0] w_signimm, w_zeroimm, w_rs_val, w_rt_val;
    logic [WIDTH-1:0] w_rt_res, w_i_res, w_memaddr, w_rf_wd;
    logic [c_RA-1:0]  w_rf_wa;
    logic             w_funct_ok, w_taken, w_memread, w_memwrite, w_rf_we;

    // Instruction field decode
    assign w_op      = r_ir[31:26];
    assign w_funct   = r_ir[5:0];
    assign w_shamt   = r_ir[10:6];
    assign w_rs      = r_ir[21 +: c_RA];
    assign w_rt      = r_ir[16 +: c_RA];
    assign w_rd      = r_ir[11 +: c_RA];
    assign w_signimm = {{(WIDTH-16){r_ir[15]}}, r_ir[15:0]};
    assign w_zeroimm = {{(WIDTH-16){1'b0}}, r_ir[15:0]};

    // Register 0 is hardwired to zero on the read side
    assign w_rs_val = (w_rs == '0) ? '0 : r_rf[w_rs];
    assign w_rt_val = (w_rt == '0) ? '0 : r_rf[w_rt];

    // R-type ALU; an unrecognised funct sends the core to HALT
    always_comb begin
        w_rt_res   = '0;
        w_funct_ok = 1'b1;
        case (w_funct)
            c_FN_ADD: w_rt_res = r_a + r_b;
            c_FN_SUB: w_rt_res = r_a - r_b;
            c_FN_AND: w_rt_res = r_a & r_b;
            c_FN_OR:  w_rt_res = r_a | r_b;
            c_FN_NOR: w_rt_res = ~(r_a | r_b);
            c_FN_SLT: w_rt_res = {{(WIDTH-1){1'b0}}, ($signed(r_a) < $signed(r_b))};
            c_FN_SLL: w_rt_res = r_b << w_shamt;
            c_FN_SRL: w_rt_res = r_b >> w_shamt;
            default:  w_funct_ok = 1'b0;
        endcase
    end

    // I-type ALU; only reached for addi/slti/andi/ori
    always_comb begin
        case (w_op)
            c_OP_ADDI: w_i_res = r_a + w_signimm;
            c_OP_SLTI: w_i_res = {{(WIDTH-1){1'b0}}, ($signed(r_a) < $signed(w_signimm))};
            c_OP_ANDI: w_i_res = r_a & w_zeroimm;
            default:   w_i_res = r_a | w_zeroimm;
        endcase
    end

    assign w_taken = (w_op == c_OP_BEQ) ? (r_a == r_b) : (r_a != r_b);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= c_FETCH;
        else       r_state <= w_next;
    end

    // Next state and Moore memory-port outputs
    always_comb begin
        w_next     = r_state;
        w_memaddr  = r_pc;
        w_memread  = 1'b0;
        w_memwrite = 1'b0;
        case (r_state)
            c_FETCH: begin
                w_memread = 1'b1;
                if (memready) w_next = c_DECODE;
            end
            c_DECODE: begin
                case (w_op)
                    c_OP_LW, c_OP_SW:                          w_next = c_MEMADR;
                    c_OP_RTYPE:                                w_next = c_RTEXEC;
                    c_OP_BEQ, c_OP_BNE:                        w_next = c_BRANCH;
                    c_OP_ADDI, c_OP_ANDI, c_OP_ORI, c_OP_SLTI: w_next = c_IEXEC;
                    c_OP_J, c_OP_JAL:                          w_next = c_JUMP;
                    default:                                   w_next = c_HALT;
                endcase
            end
            c_MEMADR: w_next = (w_op == c_OP_LW) ? c_MEMRD : c_MEMWR;
            c_MEMRD: begin
                w_memaddr = r_aluout;
                w_memread = 1'b1;
                if (memready) w_next = c_MEMWB;
            end
            c_MEMWR: begin
                w_memaddr  = r_aluout;
                w_memwrite = 1'b1;
                if (memready) w_next = c_FETCH;
            end
            c_RTEXEC: w_next = w_funct_ok ? c_ALUWB : c_HALT;
            c_IEXEC:  w_next = c_IWB;
            c_MEMWB, c_ALUWB, c_BRANCH, c_IWB, c_JUMP: w_next = c_FETCH;
            c_HALT:   w_next = c_HALT;
            default:  w_next = c_FETCH;
        endcase
    end

    // Reset forces FETCH asynchronously; the request is masked so that
    // memory sees no read while reset is held.
    assign memaddr   = w_memaddr;
    assign memread   = w_memread & ~reset;
    assign memwrite  = w_memwrite & ~reset;
    assign writedata = r_b;
    assign pc        = r_pc;
    assign halted    = (r_state == c_HALT);

    // Datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc     <= RESET_PC;
            r_ir     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_aluout <= '0;
            r_mdr    <= '0;
        end else begin
            case (r_state)
                c_FETCH: begin
                    if (memready) begin
                        r_ir <= readdata[31:0];
                        r_pc <= r_pc + WIDTH'(4);
                    end
                end
                c_DECODE: begin
                    r_a      <= w_rs_val;
                    r_b      <= w_rt_val;
                    // Branch target precomputed from the incremented pc
                    r_aluout <= r_pc + (w_signimm << 2);
                end
                c_MEMADR: r_aluout <= r_a + w_signimm;
                c_MEMRD:  if (memready) r_mdr <= readdata;
                c_RTEXEC: r_aluout <= w_rt_res;
                c_IEXEC:  r_aluout <= w_i_res;
                c_BRANCH: if (w_taken) r_pc <= r_aluout;
                c_JUMP:   r_pc <= {r_pc[WIDTH-1:28], r_ir[25:0], 2'b00};
                default:  ;
            endcase
        end
    end

    // Register-file write port (contents are not reset)
    always_comb begin
        w_rf_we = 1'b0;
        w_rf_wa = w_rt;
        w_rf_wd = r_aluout;
        case (r_state)
            c_MEMWB: begin
                w_rf_we = 1'b1;
                w_rf_wd = r_mdr;
            end
            c_ALUWB: begin
                w_rf_we = 1'b1;
                w_rf_wa = w_rd;
            end
            c_IWB: w_rf_we = 1'b1;
            c_JUMP: begin
                if (w_op == c_OP_JAL) begin
                    w_rf_we = 1'b1;
                    w_rf_wa = c_RA'(31);
                    w_rf_wd = r_pc;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_rf_we && !reset && (w_rf_wa != '0))
            r_rf[w_rf_wa] <= w_rf_wd;
    end

endmodule
`default_nettype wire

// File: tb/tb_mips_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_multi
// Purpose  : Self-checking bench for mips_multi. Small programs are loaded
//            into a word-addressed memory model; every completed store is
//            matched against a queue of expected (address, data, cycle)
//            entries, and pc / halted / bus signals are checked at chosen
//            cycles counted from reset release.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mips_multi;

    logic        clk      = 1'b0;
    logic        reset    = 1'b1;
    logic        memready = 1'b1;
    logic [31:0] memaddr, writedata, readdata, pc;
    logic        memread, memwrite, halted;

    logic [31:0] mem [0:1023];

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    int wait_cfg    = 0;
    int wcnt        = 0;
    bit hold_writes = 1'b0;

    bit          prev_wait = 1'b0;
    logic        prev_rd, prev_wr;
    logic [31:0] prev_addr;

    logic [31:0] exp_addr [$];
    logic [31:0] exp_data [$];
    int          exp_cyc  [$];

    mips_multi #(
        .WIDTH    (32),
        .RESET_PC (32'h0000_0000),
        .NREGS    (32)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .memaddr   (memaddr),
        .memread   (memread),
        .memwrite  (memwrite),
        .writedata (writedata),
        .readdata  (readdata),
        .memready  (memready),
        .pc        (pc),
        .halted    (halted)
    );

    always #5 clk = ~clk;

    assign readdata = mem[memaddr[11:2]];

    // Cycle 1 is the first cycle after reset release
    always @(posedge clk) begin
        if (reset) cyc = 1;
        else       cyc = cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Memory responder and store scoreboard; memready chosen each negedge
    always @(negedge clk) begin : p_mem
        logic [31:0] a, d;
        int          c;
        check("excl", {31'd0, memread & memwrite}, 32'd0);
        if (prev_wait && !reset) begin
            check("hold_rd", {31'd0, memread}, {31'd0, prev_rd});
            check("hold_wr", {31'd0, memwrite}, {31'd0, prev_wr});
            check("hold_addr", memaddr, prev_addr);
        end
        prev_wait = 1'b0;
        if (memread || memwrite) begin
            if ((memwrite && hold_writes) || (wcnt < wait_cfg)) begin
                memready  = 1'b0;
                wcnt      = wcnt + 1;
                prev_wait = 1'b1;
                prev_rd   = memread;
                prev_wr   = memwrite;
                prev_addr = memaddr;
            end else begin
                memready = 1'b1;
                wcnt     = 0;
                if (memwrite) begin
                    check("sb_avail", {31'd0, exp_addr.size() != 0}, 32'd1);
                    if (exp_addr.size() != 0) begin
                        a = exp_addr.pop_front();
                        d = exp_data.pop_front();
                        c = exp_cyc.pop_front();
                        check("wr_addr", memaddr, a);
                        check("wr_data", writedata, d);
                        if (c >= 0) check("wr_cycle", cyc, c);
                    end
                end
            end
        end else begin
            memready = 1'b1;
            wcnt     = 0;
        end
    end

    function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd,
                                          input int sh, input int fn);
        return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
    endfunction

    function automatic logic [31:0] enc_i(input int op, input int rs, input int rt,
                                          input logic [31:0] imm);
        return {6'(op), 5'(rs), 5'(rt), imm[15:0]};
    endfunction

    function automatic logic [31:0] enc_j(input int op, input logic [31:0] tgt);
        return {6'(op), tgt[25:0]};
    endfunction

    task automatic put(input logic [31:0] addr, input logic [31:0] word);
        mem[addr[11:2]] = word;
    endtask

    task automatic expect_wr(input logic [31:0] a, input logic [31:0] d, input int c);
        exp_addr.push_back(a);
        exp_data.push_back(d);
        exp_cyc.push_back(c);
    endtask

    task automatic begin_test();
        reset       = 1'b1;
        wait_cfg    = 0;
        hold_writes = 1'b0;
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    endtask

    task automatic release_reset();
        @(negedge clk);
        check("rst_pc", pc, 32'h0);
        check("rst_rd", {31'd0, memread}, 32'd0);
        check("rst_wr", {31'd0, memwrite}, 32'd0);
        check("rst_halt", {31'd0, halted}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic wait_cyc(input int n);
        int guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (cyc != n && guard < 2000);
        if (cyc != n) check("wait_timeout", cyc, n);
    endtask

    task automatic wait_halt();
        int guard = 0;
        while (!halted && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        check("halt_reached", {31'd0, halted}, 32'd1);
        check("halt_no_rd", {31'd0, memread}, 32'd0);
    endtask

    localparam logic [31:0] c_HALT_INSN = 32'hFC00_0000;

    initial begin : p_main
        int          regs [12] = '{6, 7, 8, 9, 15, 10, 11, 12, 13, 14, 0, 16};
        logic [31:0] vals [12] = '{32'h4, 32'hD, 32'hFFFF_FFF2, 32'h1, 32'h0, 32'hC0,
                                   32'hF, 32'h1, 32'h0000_FF00, 32'h0000_8001,
                                   32'h0, 32'h3};

        // ---- ALU program: first store of 17 to 84 lands in cycle 16 ----
        begin_test();
        put(32'h000, enc_i(8, 0, 2, 5));
        put(32'h004, enc_i(8, 0, 3, 12));
        put(32'h008, enc_r(2, 3, 4, 0, 32));
        put(32'h00C, enc_i(43, 0, 4, 84));
        put(32'h010, enc_j(2, 32'h40));
        put(32'h100, enc_r(2, 3, 5, 0, 34));              // sub  -> -7
        put(32'h104, enc_i(43, 0, 5, 32'h200));
        put(32'h108, enc_r(2, 3, 6, 0, 36));              // and
        put(32'h10C, enc_r(2, 3, 7, 0, 37));              // or
        put(32'h110, enc_r(2, 3, 8, 0, 39));              // nor
        put(32'h114, enc_r(5, 2, 9, 0, 42));              // slt -7<5
        put(32'h118, enc_r(2, 5, 15, 0, 42));             // slt 5<-7
        put(32'h11C, enc_r(0, 3, 10, 4, 0));              // sll
        put(32'h120, enc_r(0, 5, 11, 28, 2));             // srl
        put(32'h124, enc_i(10, 5, 12, -6));               // slti
        put(32'h128, enc_i(12, 5, 13, 32'hFF00));         // andi
        put(32'h12C, enc_i(13, 0, 14, 32'h8001));         // ori
        put(32'h130, enc_i(8, 2, 0, 1));                  // addi $0 discarded
        put(32'h134, enc_i(8, 5, 16, 10));                // wraps to 3
        for (int k = 0; k < 12; k++)
            put(32'h138 + 4 * k, enc_i(43, 0, regs[k], 32'h204 + 4 * k));
        put(32'h168, c_HALT_INSN);
        expect_wr(32'd84, 32'd17, 16);
        expect_wr(32'h200, 32'hFFFF_FFF9, -1);
        for (int k = 0; k < 12; k++) expect_wr(32'h204 + 4 * k, vals[k], -1);
        release_reset();
        wait_cyc(1);
        check("first_fetch_addr", memaddr, 32'h0);
        check("first_fetch_rd", {31'd0, memread}, 32'd1);
        wait_halt();
        check("alu_sb_drain", exp_addr.size(), 32'd0);

        // ---- lw with 3 wait cycles on every request ----
        begin_test();
        put(32'd84, 32'd17);
        put(32'h000, enc_i(35, 0, 5, 84));
        put(32'h004, enc_i(43, 0, 5, 32'h200));
        put(32'h008, c_HALT_INSN);
        wait_cfg = 3;
        expect_wr(32'h200, 32'd17, -1);
        release_reset();
        wait_cyc(4);
        check("lw_fetch_rd", {31'd0, memread}, 32'd1);
        wait_cyc(7);
        check("lw_memrd_addr", memaddr, 32'd84);
        check("lw_memrd_rd", {31'd0, memread}, 32'd1);
        wait_cyc(11);
        check("lw_wb_no_rd", {31'd0, memread}, 32'd0);
        wait_cyc(12);
        check("lw_next_fetch", memaddr, 32'h4);
        check("lw_next_rd", {31'd0, memread}, 32'd1);
        wait_halt();
        check("lw_sb_drain", exp_addr.size(), 32'd0);

        // ---- bne not taken, then beq self-loop every 3 cycles ----
        begin_test();
        put(32'h000, enc_i(5, 0, 0, 5));
        put(32'h004, enc_i(4, 0, 0, -1));
        release_reset();
        wait_cyc(3);
        check("bne_pc", pc, 32'h4);
        wait_cyc(4);
        check("beq_fetch1", memaddr, 32'h4);
        wait_cyc(6);
        check("beq_pc_inc", pc, 32'h8);
        wait_cyc(7);
        check("beq_fetch2", memaddr, 32'h4);
        wait_cyc(10);
        check("beq_fetch3", memaddr, 32'h4);
        check("beq_fetch3_rd", {31'd0, memread}, 32'd1);

        // ---- j to 0x10, jal 0x40 -> $31=0x14, pc=0x100 ----
        begin_test();
        put(32'h000, enc_j(2, 32'h4));
        put(32'h010, enc_j(3, 32'h40));
        put(32'h100, enc_i(43, 0, 31, 32'h200));
        put(32'h104, c_HALT_INSN);
        expect_wr(32'h200, 32'h14, -1);
        release_reset();
        wait_cyc(4);
        check("j_target", memaddr, 32'h10);
        wait_cyc(7);
        check("jal_target", memaddr, 32'h100);
        check("jal_pc", pc, 32'h100);
        wait_halt();
        check("jal_sb_drain", exp_addr.size(), 32'd0);

        // ---- unsupported opcode halts two cycles after fetch ----
        begin_test();
        put(32'h000, c_HALT_INSN);
        release_reset();
        wait_cyc(2);
        check("op_halt_early", {31'd0, halted}, 32'd0);
        wait_cyc(3);
        check("op_halt", {31'd0, halted}, 32'd1);
        check("op_halt_rd", {31'd0, memread}, 32'd0);
        check("op_halt_wr", {31'd0, memwrite}, 32'd0);
        wait_cyc(8);
        check("op_halt_pc", pc, 32'h4);
        check("op_halt_stays", {31'd0, halted}, 32'd1);

        // ---- unknown funct halts from RTEXEC ----
        begin_test();
        put(32'h000, enc_r(0, 0, 0, 0, 63));
        release_reset();
        wait_cyc(3);
        check("fn_halt_early", {31'd0, halted}, 32'd0);
        wait_cyc(4);
        check("fn_halt", {31'd0, halted}, 32'd1);

        // ---- reset pulsed while MEMWR is stalled ----
        begin_test();
        put(32'h000, enc_i(8, 0, 2, 7));
        put(32'h004, enc_i(43, 0, 2, 32'h200));
        put(32'h008, c_HALT_INSN);
        hold_writes = 1'b1;
        release_reset();
        wait_cyc(9);
        check("memwr_stalled", {31'd0, memwrite}, 32'd1);
        check("memwr_addr", memaddr, 32'h200);
        #2 reset = 1'b1;
        #1;
        check("abort_wr", {31'd0, memwrite}, 32'd0);
        check("abort_rd", {31'd0, memread}, 32'd0);
        check("abort_pc", pc, 32'h0);
        hold_writes = 1'b0;
        expect_wr(32'h200, 32'd7, 8);
        release_reset();
        wait_cyc(1);
        check("refetch_addr", memaddr, 32'h0);
        check("refetch_rd", {31'd0, memread}, 32'd1);
        wait_halt();
        check("abort_sb_drain", exp_addr.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin : p_watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
